regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources: source 0 is the ALU/branch-link path and source 1 is the load/HI-LO path. Each source writes into its own small FIFO through a valid/ready handshake. A round-robin arbiter drains the FIFOs and drives one registered write per cycle into the register file's RegWrite/WriteReg/WriteData port. An optional pending-write mask tells the hazard logic which registers have writes still in flight.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_fifo.sv | 79 +++++++
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the register-file writeback arbiter
package wb_arb_pkg;

    localparam int NUM_SRC   = 2;
    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source writeback FIFO; WB_ARB_PENDING_EN exports entry valid/addr vectors
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  wb_req_t                  din,
    output wb_req_t                  dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
`ifdef WB_ARB_PENDING_EN
    ,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_req_t          mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [DEPTH-1:0] vld;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // wptr == rptr only when empty or full, so a push and a pop never touch the same vld bit
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (do_push) begin
                vld[wptr] <= 1'b1;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef WB_ARB_PENDING_EN
    assign entry_valid = vld;
    always_comb begin
        entry_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin share of the register file write port; WB_ARB_PENDING_EN builds the pending mask
module regfile_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    output logic                        rf_we,
    output logic [ADDR_W-1:0]           rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic [REG_COUNT-1:0]        pending,
    output logic                        idle
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_req_t              din   [NUM_SRC];
    wb_req_t              dout  [NUM_SRC];
    logic [CW-1:0]        count [NUM_SRC];
    logic [NUM_SRC-1:0]   full;
    logic [NUM_SRC-1:0]   empty;
    logic [NUM_SRC-1:0]   push;
    logic [NUM_SRC-1:0]   pop;
    logic                 last_grant;
    logic                 win;
    logic                 grant_any;
    wb_req_t              head;

`ifdef WB_ARB_PENDING_EN
    logic [NUM_SRC-1:0][DEPTH-1:0]             ev;
    logic [NUM_SRC-1:0][DEPTH-1:0][ADDR_W-1:0] ea;
`endif

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign din[g].addr  = src_addr[ADDR_W*g +: ADDR_W];
        assign din[g].data  = src_data[DATA_W*g +: DATA_W];
        assign src_ready[g] = ~full[g];
        // writes to r0 complete the handshake but are dropped here
        assign push[g] = src_valid[g] & src_ready[g] & ~reset
                       & (src_addr[ADDR_W*g +: ADDR_W] != '0);

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push        (push[g]),
            .pop         (pop[g]),
            .din         (din[g]),
            .dout        (dout[g]),
            .count       (count[g]),
            .full        (full[g]),
            .empty       (empty[g])
`ifdef WB_ARB_PENDING_EN
            ,
            .entry_valid (ev[g]),
            .entry_addr  (ea[g])
`endif
        );
    end

    // round robin: on contention the source not granted last time wins
    always_comb begin
        grant_any = |(~empty);
        win       = 1'b0;
        if (&(~empty)) begin
            win = ~last_grant;
        end else begin
            win = ~empty[1];
        end
        pop = '0;
        if (grant_any) begin
            pop[win] = 1'b1;
        end
        head = win ? dout[1] : dout[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            last_grant <= 1'b1;
        end else begin
            rf_we <= grant_any;
            if (grant_any) begin
                rf_waddr   <= head.addr;
                rf_wdata   <= head.data;
                last_grant <= win;
            end
        end
    end

    assign idle = (count[0] == '0) && (count[1] == '0) && !rf_we;

`ifdef WB_ARB_PENDING_EN
    always_comb begin
        pending = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (ev[s][e]) begin
                    pending[ea[s][e]] = 1'b1;
                end
            end
        end
        if (rf_we) begin
            pending[rf_waddr] = 1'b1;
        end
        pending[0] = 1'b0;
    end
`else
    assign pending = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  src_valid = '0;
    logic [1:0]  src_ready;
    logic [9:0]  src_addr = '0;
    logic [63:0] src_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;
    logic        idle;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pending   (pending),
        .idle      (idle)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        idl;
        logic [31:0] pend;
    } vec_t;

    localparam int NV = 28;
    localparam logic [31:0] A = 32'hA000_0000;
    vec_t tbl [NV];

    function automatic logic [31:0] rb(input int n);
        return 32'(1) << n;
    endfunction

    function automatic vec_t mk(input logic rst, input logic [1:0] v,
                                input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic [1:0] rdy, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic idl, input logic [31:0] pend);
        vec_t t;
        t.rst = rst; t.v = v; t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
        t.rdy = rdy; t.we = we; t.wa = wa; t.wd = wd; t.idl = idl; t.pend = pend;
        return t;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
        end
    endtask

    task automatic check_outputs(input int row, input vec_t t);
        logic [31:0] exp_pend;
`ifdef WB_ARB_PENDING_EN
        exp_pend = t.pend;
`else
        exp_pend = 32'h0;
`endif
        chk("src_ready", row, 32'(src_ready), 32'(t.rdy));
        chk("rf_we",     row, 32'(rf_we),     32'(t.we));
        chk("rf_waddr",  row, 32'(rf_waddr),  32'(t.wa));
        chk("rf_wdata",  row, rf_wdata,       t.wd);
        chk("idle",      row, 32'(idle),      32'(t.idl));
        chk("pending",   row, pending,        exp_pend);
    endtask

    initial begin
        // reset state, single write, r0 discard
        tbl[0]  = mk(1, 2'b00, 0, 0, 0, 0,                2'b11, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 2'b01, 5, 32'hDEADBEEF, 0, 0,     2'b11, 0, 0, 0, 0, rb(5));
        tbl[2]  = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 1, 5, 32'hDEADBEEF, 0, rb(5));
        tbl[3]  = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 0, 5, 32'hDEADBEEF, 1, 0);
        tbl[4]  = mk(0, 2'b01, 0, 32'h1234, 0, 0,         2'b11, 0, 5, 32'hDEADBEEF, 1, 0);
        tbl[5]  = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 0, 5, 32'hDEADBEEF, 1, 0);
        // reset, then contention: issue order 1,9,2,10,3,11,4,12 with backpressure
        tbl[6]  = mk(1, 2'b00, 0, 0, 0, 0,                2'b11, 0, 0, 0, 1, 0);
        tbl[7]  = mk(0, 2'b11, 1, A|1, 9, A|9,            2'b11, 0, 0, 0, 0, rb(1)|rb(9));
        tbl[8]  = mk(0, 2'b11, 2, A|2, 10, A|10,          2'b01, 1, 1, A|1, 0, rb(1)|rb(2)|rb(9)|rb(10));
        tbl[9]  = mk(0, 2'b11, 3, A|3, 11, A|11,          2'b10, 1, 9, A|9, 0, rb(2)|rb(3)|rb(9)|rb(10));
        tbl[10] = mk(0, 2'b11, 4, A|4, 11, A|11,          2'b01, 1, 2, A|2, 0, rb(2)|rb(3)|rb(10)|rb(11));
        tbl[11] = mk(0, 2'b11, 4, A|4, 12, A|12,          2'b10, 1, 10, A|10, 0, rb(3)|rb(4)|rb(10)|rb(11));
        tbl[12] = mk(0, 2'b10, 0, 0, 12, A|12,            2'b01, 1, 3, A|3, 0, rb(3)|rb(4)|rb(11)|rb(12));
        tbl[13] = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 1, 11, A|11, 0, rb(4)|rb(11)|rb(12));
        tbl[14] = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 1, 4, A|4, 0, rb(4)|rb(12));
        tbl[15] = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 1, 12, A|12, 0, rb(12));
        tbl[16] = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 0, 12, A|12, 1, 0);
        // reset mid-operation with handshakes presented during reset
        tbl[17] = mk(0, 2'b11, 20, 32'h20, 21, 32'h21,    2'b11, 0, 12, A|12, 0, rb(20)|rb(21));
        tbl[18] = mk(1, 2'b11, 22, 32'h22, 23, 32'h23,    2'b11, 0, 0, 0, 1, 0);
        tbl[19] = mk(0, 2'b10, 0, 0, 17, 32'h55,          2'b11, 0, 0, 0, 0, rb(17));
        tbl[20] = mk(0, 2'b11, 6, 32'h66, 18, 32'h88,     2'b11, 1, 17, 32'h55, 0, rb(6)|rb(17)|rb(18));
        tbl[21] = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 1, 6, 32'h66, 0, rb(6)|rb(18));
        tbl[22] = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 1, 18, 32'h88, 0, rb(18));
        tbl[23] = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 0, 18, 32'h88, 1, 0);
        // same register twice from source 1
        tbl[24] = mk(0, 2'b10, 0, 0, 7, 32'hA,            2'b11, 0, 18, 32'h88, 0, rb(7));
        tbl[25] = mk(0, 2'b10, 0, 0, 7, 32'hB,            2'b11, 1, 7, 32'hA, 0, rb(7));
        tbl[26] = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 1, 7, 32'hB, 0, rb(7));
        tbl[27] = mk(0, 2'b00, 0, 0, 0, 0,                2'b11, 0, 7, 32'hB, 1, 0);

        for (int i = 0; i < NV; i++) begin
            reset     = tbl[i].rst;
            src_valid = tbl[i].v;
            src_addr  = {tbl[i].a1, tbl[i].a0};
            src_data  = {tbl[i].d1, tbl[i].d0};
            @(posedge clk);
            #1;
            check_outputs(i, tbl[i]);
        end

        // bounded wait for the issue of a lone source-0 write
        begin
            int n;
            n = 0;
            src_valid = 2'b01;
            src_addr  = {5'd0, 5'd3};
            src_data  = {32'h0, 32'h3333_0003};
            @(posedge clk);
            #1;
            src_valid = 2'b00;
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk);
                #1;
                if (rf_we) begin
                    n = k;
                    break;
                end
            end
            chk("lone_latency", 100, 32'(n), 32'd1);
            chk("lone_waddr",   100, 32'(rf_waddr), 32'd3);
            chk("lone_wdata",   100, rf_wdata, 32'h3333_0003);
            @(posedge clk);
            #1;
            chk("lone_drop_we", 101, 32'(rf_we), 32'd0);
            chk("lone_idle",    101, 32'(idle), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
